// File: rtl/tdm_mux_16_1_if.sv
// ---------------------------------------------------------------------------
// tdm_mux_16_1_if
//   Bundles the channel-side inputs and the serial-line outputs of the
//   16:1 TDM multiplexer.
//   slave  : the multiplexer (consumes Enable/Data/Request, drives the line)
//   master : whoever feeds the channels and watches the line
//   Signals:
//     Enable_In        1   run / freeze
//     Data_In          16  channel data, bit k = channel k
//     Request_In       16  per-channel request (round-robin mode only)
//     Data_Out         1   serialised bit of the current channel
//     Select_Out       4   current channel index (far-end DEMUX select)
//     Valid_Out        1   line carries a live slot
//     Frame_Start_Out  1   first cycle of a channel-0 slot (scan mode)
//     Ack_Out          16  one-hot, last cycle of a channel slot
// ---------------------------------------------------------------------------
interface tdm_mux_16_1_if;
  logic        Enable_In;
  logic [15:0] Data_In;
  logic [15:0] Request_In;
  logic        Data_Out;
  logic [3:0]  Select_Out;
  logic        Valid_Out;
  logic        Frame_Start_Out;
  logic [15:0] Ack_Out;

  modport slave (
    input  Enable_In, Data_In, Request_In,
    output Data_Out, Select_Out, Valid_Out, Frame_Start_Out, Ack_Out
  );

  modport master (
    output Enable_In, Data_In, Request_In,
    input  Data_Out, Select_Out, Valid_Out, Frame_Start_Out, Ack_Out
  );
endinterface

// File: rtl/tdm_mux_16_1.sv
// ---------------------------------------------------------------------------
// tdm_mux_16_1
//   Transmit end of a 1:16 TDM link. Serialises 16 single-bit channels onto
//   one line (Data_Out + Select_Out + Valid_Out) for a far-end DEMUX.
//   Each channel owns a slot of DWELL_CYCLES consecutive output cycles.
//   SKIP_IDLE=0 : fixed scan 0..15, continuously valid while enabled.
//   SKIP_IDLE=1 : round-robin over Request_In, idle when nobody requests.
//   Ports:
//     Clock_In   in  single clock, rising edge
//     Reset_In   in  synchronous, active-high
//     bus        slave modport of tdm_mux_16_1_if (channels in, line out)
//   All outputs are registered; Data_Out shows Data_In[k] sampled at the
//   edge that produced the slot cycle (one-cycle latency).
// ---------------------------------------------------------------------------
module tdm_mux_16_1 #(
  parameter int DWELL_CYCLES = 1,    // 1..256
  parameter bit SKIP_IDLE    = 1'b0
) (
  input  logic           Clock_In,
  input  logic           Reset_In,
  tdm_mux_16_1_if.slave  bus
);

  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    IDLE  = 2'd1,
    DWELL = 2'd2
  } state_t;

  localparam state_t RESET_STATE = SKIP_IDLE ? IDLE : SCAN;

  // First requesting channel after 'last', wrapping mod 16. 'last' itself is
  // checked last, so a requester held through its ack waits for the others.
  function automatic logic [3:0] rr_pick(input logic [15:0] req,
                                         input logic [3:0]  last);
    logic [3:0] pick;
    logic [3:0] idx;
    pick = last;
    for (int i = 15; i >= 0; i--) begin
      idx = last + 4'(i + 1);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

  state_t        state_reg;
  logic [3:0]    ch_reg;     // channel of the next slot cycle to emit
  logic [CW-1:0] cnt_reg;    // position of the next slot cycle within its slot
  logic [3:0]    ptr_reg;    // last granted channel
  logic          data_out_reg;
  logic [3:0]    select_reg;
  logic          valid_reg;
  logic          frame_reg;
  logic [15:0]   ack_reg;

  logic          any_req;
  logic [3:0]    first_grant;
  logic          slot_live;
  logic [3:0]    cur_ch;
  logic [CW-1:0] cur_cnt;
  logic          last_cycle;
  logic [3:0]    next_grant;

  // In IDLE the grant and the first slot cycle happen on the same edge, so
  // the cycle being emitted now comes either from the held slot or from a
  // fresh arbitration. A second arbiter, seeded with that channel, picks the
  // follower when this cycle closes the slot (covers DWELL_CYCLES=1 too).
  always_comb begin
    any_req     = |bus.Request_In;
    first_grant = rr_pick(bus.Request_In, ptr_reg);
    slot_live   = (state_reg != IDLE) || any_req;
    cur_ch      = (state_reg == IDLE) ? first_grant : ch_reg;
    cur_cnt     = (state_reg == IDLE) ? '0 : cnt_reg;
    last_cycle  = (cur_cnt == LAST_CNT);
    next_grant  = rr_pick(bus.Request_In, cur_ch);
  end

  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state_reg    <= RESET_STATE;
      ch_reg       <= 4'd0;
      cnt_reg      <= '0;
      ptr_reg      <= 4'd15;
      data_out_reg <= 1'b0;
      select_reg   <= 4'd0;
      valid_reg    <= 1'b0;
      frame_reg    <= 1'b0;
      ack_reg      <= 16'h0000;
    end else if (!bus.Enable_In || !slot_live) begin
      // Paused or idle: slot state frozen, line quiet, select holds.
      data_out_reg <= 1'b0;
      valid_reg    <= 1'b0;
      frame_reg    <= 1'b0;
      ack_reg      <= 16'h0000;
    end else begin
      data_out_reg <= bus.Data_In[cur_ch];
      select_reg   <= cur_ch;
      valid_reg    <= 1'b1;
      ack_reg      <= last_cycle ? (16'd1 << cur_ch) : 16'h0000;
      // Tied to slot position, so a resumed slot never re-issues it.
      frame_reg    <= (SKIP_IDLE == 1'b0) && (cur_ch == 4'd0) && (cur_cnt == '0);
      if (!last_cycle) begin
        cnt_reg   <= cur_cnt + 1'b1;
        ch_reg    <= cur_ch;
        ptr_reg   <= cur_ch;
        state_reg <= SKIP_IDLE ? DWELL : SCAN;
      end else begin
        cnt_reg <= '0;
        if (SKIP_IDLE == 1'b0) begin
          ch_reg    <= cur_ch + 4'd1;
          state_reg <= SCAN;
        end else if (any_req) begin
          ch_reg    <= next_grant;
          ptr_reg   <= next_grant;
          state_reg <= DWELL;
        end else begin
          ch_reg    <= cur_ch;
          ptr_reg   <= cur_ch;
          state_reg <= IDLE;
        end
      end
    end
  end

  assign bus.Data_Out        = data_out_reg;
  assign bus.Select_Out      = select_reg;
  assign bus.Valid_Out       = valid_reg;
  assign bus.Frame_Start_Out = frame_reg;
  assign bus.Ack_Out         = ack_reg;

endmodule
